flag_unit: RTL and testbench

- Architectural flag register and branch-condition evaluator.
- Consumes the O/S/C/Z outputs of the ALU at write-back and updates only the flags the committing opcode is defined to affect.
- Answers condition queries from the branch logic with a registered result.
- Sits between the ALU write-back stage and the jump/branch control.

---
 rtl/flag_unit.sv | 135 +++++++++++++
 tb/tb_flag_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
// Architectural {O,S,C,Z} flag register with registered branch-condition evaluation.
// Optional forwarding of same-cycle flag updates into queries: define FLAG_BYPASS_EN.
module flag_unit #(
   parameter int unsigned FLAG_W = 4,
   parameter int unsigned COND_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [4:0]        alu_op,
   input  logic              alu_O,
   input  logic              alu_S,
   input  logic              alu_C,
   input  logic              alu_Z,
   input  logic              flag_we_ext,
   input  logic [FLAG_W-1:0] flag_in,
   input  logic              cond_valid,
   input  logic [COND_W-1:0] cond_sel,
   input  logic              cond_inv,
   output logic              stall,
   output logic              cond_ready,
   output logic              cond_result,
   output logic [FLAG_W-1:0] flags
);

   // ALU opcode encoding; codes 24..31 are undefined and update nothing.
   localparam logic [4:0] OpAdd      = 5'd0;
   localparam logic [4:0] OpAddInc   = 5'd1;
   localparam logic [4:0] OpIncA     = 5'd2;
   localparam logic [4:0] OpSubDec   = 5'd3;
   localparam logic [4:0] OpSub      = 5'd4;
   localparam logic [4:0] OpDecA     = 5'd5;
   localparam logic [4:0] OpLsl      = 5'd6;
   localparam logic [4:0] OpAsr      = 5'd7;
   localparam logic [4:0] OpZeros    = 5'd8;
   localparam logic [4:0] OpAnd      = 5'd9;
   localparam logic [4:0] OpAndNotA  = 5'd10;
   localparam logic [4:0] OpAndNotB  = 5'd11;
   localparam logic [4:0] OpPassA    = 5'd12;
   localparam logic [4:0] OpXor      = 5'd13;
   localparam logic [4:0] OpOr       = 5'd14;
   localparam logic [4:0] OpNand     = 5'd15;
   localparam logic [4:0] OpXnor     = 5'd16;
   localparam logic [4:0] OpPassNotA = 5'd17;
   localparam logic [4:0] OpOrNotA   = 5'd18;
   localparam logic [4:0] OpPassNotB = 5'd19;
   localparam logic [4:0] OpOrNotB   = 5'd20;
   localparam logic [4:0] OpNor      = 5'd21;

   typedef enum logic [0:0] {StIdle, StResp} state_e;

   state_e            state_q, state_d;
   logic [FLAG_W-1:0] flags_q, flags_d;
   logic [FLAG_W-1:0] op_mask, upd_mask, alu_flags, eval_flags;
   logic              result_q, cond_eval, accept;

   assign alu_flags = {alu_O, alu_S, alu_C, alu_Z};

   always_comb begin
      op_mask = '0;
      case (alu_op)
         OpAdd, OpAddInc, OpIncA, OpSubDec, OpSub, OpDecA: op_mask = 4'b1111;
         OpLsl, OpAsr:                                      op_mask = 4'b0111;
         OpZeros:                                           op_mask = 4'b0001;
         OpAnd, OpAndNotA, OpAndNotB, OpPassA, OpXor, OpOr, OpNand, OpXnor,
         OpPassNotA, OpOrNotA, OpPassNotB, OpOrNotB, OpNor: op_mask = 4'b0101;
         default:                                           op_mask = 4'b0000;
      endcase
   end

   // A context restore overrides any ALU update in the same cycle.
   always_comb begin
      upd_mask = '0;
      flags_d  = flags_q;
      if (flag_we_ext) begin
         upd_mask = '1;
         flags_d  = flag_in;
      end else if (alu_valid) begin
         upd_mask = op_mask;
         flags_d  = (flags_q & ~op_mask) | (alu_flags & op_mask);
      end
   end

`ifdef FLAG_BYPASS_EN
   assign stall      = 1'b0;
   assign eval_flags = flags_d;
`else
   assign stall      = !rst && cond_valid && (upd_mask != '0);
   assign eval_flags = flags_q;
`endif

   assign accept = cond_valid && !stall;

   // Reserved selectors force 0 regardless of cond_inv.
   always_comb begin
      cond_eval = 1'b0;
      case (cond_sel)
         3'd0:    cond_eval = 1'b1 ^ cond_inv;
         3'd1:    cond_eval = eval_flags[2] ^ cond_inv;
         3'd2:    cond_eval = eval_flags[0] ^ cond_inv;
         3'd3:    cond_eval = eval_flags[1] ^ cond_inv;
         3'd4:    cond_eval = (eval_flags[2] | eval_flags[0]) ^ cond_inv;
         3'd5:    cond_eval = eval_flags[3] ^ cond_inv;
         default: cond_eval = 1'b0;
      endcase
   end

   always_comb begin
      state_d = StIdle;
      unique case (state_q)
         StIdle:  state_d = accept ? StResp : StIdle;
         StResp:  state_d = accept ? StResp : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         flags_q  <= '0;
         result_q <= 1'b0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
         if (accept) begin
            result_q <= cond_eval;
         end
      end
   end

   assign cond_ready  = (state_q == StResp);
   assign cond_result = result_q;
   assign flags       = flags_q;

endmodule

// File: tb/tb_flag_unit.sv
// Directed self-checking bench for flag_unit; expectations follow FLAG_BYPASS_EN if defined.
module tb_flag_unit;

   localparam logic [4:0] OpAdd   = 5'd0;
   localparam logic [4:0] OpSub   = 5'd4;
   localparam logic [4:0] OpLsl   = 5'd6;
   localparam logic [4:0] OpZeros = 5'd8;
   localparam logic [4:0] OpAnd   = 5'd9;
   localparam logic [4:0] OpPassB = 5'd22;
   localparam logic [4:0] OpOnes  = 5'd23;
   localparam logic [4:0] OpUndef = 5'd31;

   logic       clk = 1'b0;
   logic       rst;
   logic       alu_valid;
   logic [4:0] alu_op;
   logic       alu_O, alu_S, alu_C, alu_Z;
   logic       flag_we_ext;
   logic [3:0] flag_in;
   logic       cond_valid;
   logic [2:0] cond_sel;
   logic       cond_inv;
   logic       stall, cond_ready, cond_result;
   logic [3:0] flags;

   int checks   = 0;
   int failures = 0;

   flag_unit dut (
      .clk        (clk),
      .rst        (rst),
      .alu_valid  (alu_valid),
      .alu_op     (alu_op),
      .alu_O      (alu_O),
      .alu_S      (alu_S),
      .alu_C      (alu_C),
      .alu_Z      (alu_Z),
      .flag_we_ext(flag_we_ext),
      .flag_in    (flag_in),
      .cond_valid (cond_valid),
      .cond_sel   (cond_sel),
      .cond_inv   (cond_inv),
      .stall      (stall),
      .cond_ready (cond_ready),
      .cond_result(cond_result),
      .flags      (flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alu(input logic v, input logic [4:0] op, input logic [3:0] osc);
      alu_valid = v;
      alu_op    = op;
      {alu_O, alu_S, alu_C, alu_Z} = osc;
   endtask

   task automatic query(input logic v, input logic [2:0] sel, input logic inv);
      cond_valid = v;
      cond_sel   = sel;
      cond_inv   = inv;
   endtask

   initial begin
      rst = 1'b1;
      flag_we_ext = 1'b0;
      flag_in = 4'h0;
      alu(1'b1, OpAdd, 4'hF);
      query(1'b1, 3'd0, 1'b0);
      #12;
      chk("reset_flags", flags, 4'h0);
      chk("reset_ready", {3'b0, cond_ready}, 4'h0);
      chk("reset_result", {3'b0, cond_result}, 4'h0);
      chk("reset_stall", {3'b0, stall}, 4'h0);
      alu(1'b0, OpAdd, 4'h0);
      query(1'b0, 3'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // 1: mid-cycle async reset
      flag_we_ext = 1'b1; flag_in = 4'hF;
      tick();
      flag_we_ext = 1'b0;
      chk("t1_load_ones", flags, 4'hF);
      query(1'b1, 3'd0, 1'b0);
      tick();
      query(1'b0, 3'd0, 1'b0);
      chk("t1_ready_pre", {3'b0, cond_ready}, 4'h1);
      #2 rst = 1'b1;
      #1;
      chk("t1_async_flags", flags, 4'h0);
      chk("t1_async_ready", {3'b0, cond_ready}, 4'h0);
      @(negedge clk);
      rst = 1'b0;
      query(1'b1, 3'd0, 1'b0);
      tick();
      query(1'b0, 3'd0, 1'b0);
      chk("t1_true_ready", {3'b0, cond_ready}, 4'h1);
      chk("t1_true_result", {3'b0, cond_result}, 4'h1);
      tick();
      chk("t1_ready_drop", {3'b0, cond_ready}, 4'h0);

      // 2: arithmetic update
      alu(1'b1, OpSub, 4'b0011);
      tick();
      alu(1'b0, OpSub, 4'h0);
      chk("t2_flags", flags, 4'b0011);
      query(1'b1, 3'd2, 1'b0);
      #1 chk("t2_stall", {3'b0, stall}, 4'h0);
      tick();
      chk("t2_zero_ready", {3'b0, cond_ready}, 4'h1);
      chk("t2_zero_result", {3'b0, cond_result}, 4'h1);
      query(1'b1, 3'd3, 1'b1);
      tick();
      query(1'b0, 3'd0, 1'b0);
      chk("t2_ncarry_result", {3'b0, cond_result}, 4'h0);
      tick();
      chk("t2_idle", {3'b0, cond_ready}, 4'h0);

      // 3: partial masks
      flag_we_ext = 1'b1; flag_in = 4'hF;
      tick();
      flag_we_ext = 1'b0;
      alu(1'b1, OpAnd, 4'h0);
      tick();
      chk("t3_and", flags, 4'b1010);
      alu(1'b1, OpLsl, 4'h0);
      tick();
      chk("t3_lsl", flags, 4'b1000);
      alu(1'b1, OpPassB, 4'hF);
      tick();
      chk("t3_passb", flags, 4'b1000);
      alu(1'b1, OpUndef, 4'hF);
      tick();
      alu(1'b0, OpAdd, 4'h0);
      chk("t3_undef", flags, 4'b1000);

      // 4: hazard
      flag_we_ext = 1'b1; flag_in = 4'h0;
      tick();
      flag_we_ext = 1'b0;
      alu(1'b1, OpZeros, 4'b0001);
      query(1'b1, 3'd2, 1'b0);
      #1;
`ifdef FLAG_BYPASS_EN
      chk("t4_stall", {3'b0, stall}, 4'h0);
      tick();
      alu(1'b0, OpAdd, 4'h0);
      query(1'b0, 3'd0, 1'b0);
      chk("t4_ready", {3'b0, cond_ready}, 4'h1);
      chk("t4_result", {3'b0, cond_result}, 4'h1);
`else
      chk("t4_stall", {3'b0, stall}, 4'h1);
      tick();
      alu(1'b0, OpAdd, 4'h0);
      #1;
      chk("t4_unstall", {3'b0, stall}, 4'h0);
      chk("t4_not_ready", {3'b0, cond_ready}, 4'h0);
      tick();
      query(1'b0, 3'd0, 1'b0);
      chk("t4_ready", {3'b0, cond_ready}, 4'h1);
      chk("t4_result", {3'b0, cond_result}, 4'h1);
`endif
      tick();
      flag_we_ext = 1'b1; flag_in = 4'h0;
      tick();
      flag_we_ext = 1'b0;
      alu(1'b1, OpOnes, 4'hF);
      query(1'b1, 3'd2, 1'b0);
      #1 chk("t4_ones_stall", {3'b0, stall}, 4'h0);
      tick();
      alu(1'b0, OpAdd, 4'h0);
      query(1'b0, 3'd0, 1'b0);
      chk("t4_ones_ready", {3'b0, cond_ready}, 4'h1);
      chk("t4_ones_result", {3'b0, cond_result}, 4'h0);
      chk("t4_ones_flags", flags, 4'h0);
      tick();

      // 5: external load beats ALU
      flag_we_ext = 1'b1; flag_in = 4'b0101;
      alu(1'b1, OpAdd, 4'hF);
      tick();
      flag_we_ext = 1'b0;
      alu(1'b0, OpAdd, 4'h0);
      chk("t5_flags", flags, 4'b0101);
      query(1'b1, 3'd4, 1'b0);
      tick();
      chk("t5_negzero", {3'b0, cond_result}, 4'h1);
      query(1'b1, 3'd6, 1'b1);
      tick();
      query(1'b0, 3'd0, 1'b0);
      chk("t5_reserved_ready", {3'b0, cond_ready}, 4'h1);
      chk("t5_reserved", {3'b0, cond_result}, 4'h0);
      tick();

      // 6: back-to-back queries
      flag_we_ext = 1'b1; flag_in = 4'b1000;
      tick();
      flag_we_ext = 1'b0;
      query(1'b1, 3'd0, 1'b0);
      tick();
      chk("t6_r0", {2'b0, cond_ready, cond_result}, 4'b0011);
      query(1'b1, 3'd5, 1'b0);
      tick();
      chk("t6_r1", {2'b0, cond_ready, cond_result}, 4'b0011);
      query(1'b1, 3'd1, 1'b0);
      tick();
      query(1'b0, 3'd0, 1'b0);
      chk("t6_r2", {2'b0, cond_ready, cond_result}, 4'b0010);
      tick();
      chk("t6_idle", {3'b0, cond_ready}, 4'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
